// File: rtl/yep_if_pkg.sv
// ============================================================================
// Module      : yep_if_pkg
// Description : Shared constants and the fetch-action encoding for the IF stage.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package yep_if_pkg;

    localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] DEF_NOP_WORD     = 32'h0000_0000;
    localparam logic [31:0] PC_INC           = 32'd4;

    // Listed highest priority first; exactly one applies per edge.
    typedef enum logic [2:0] {
        ACT_SMC   = 3'd0,
        ACT_STALL = 3'd1,
        ACT_REDIR = 3'd2,
        ACT_SMC2  = 3'd3,
        ACT_MISS  = 3'd4,
        ACT_FETCH = 3'd5
    } if_action_e;

endpackage

`default_nettype wire

// File: rtl/if_perfcnt.sv
// ============================================================================
// Module      : if_perfcnt
// Description : Stall / flush / miss event counters; built only with IF_PERFCNT_EN.
// Revision    : 1.0
// ============================================================================
`default_nettype none

`ifdef IF_PERFCNT_EN
module if_perfcnt
    import yep_if_pkg::*;
(
    input  logic        CLK,
    input  logic        RST,
    input  if_action_e  act,
    output logic [31:0] STALL_CNT,
    output logic [31:0] FLUSH_CNT,
    output logic [31:0] IMISS_CNT
);

    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;
    logic [31:0] imiss_cnt_q, imiss_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        imiss_cnt_d = imiss_cnt_q;
        case (act)
            ACT_STALL:                     stall_cnt_d = stall_cnt_q + 32'd1;
            ACT_SMC, ACT_REDIR, ACT_SMC2:  flush_cnt_d = flush_cnt_q + 32'd1;
            ACT_MISS:                      imiss_cnt_d = imiss_cnt_q + 32'd1;
            default: ;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            imiss_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            imiss_cnt_q <= imiss_cnt_d;
        end
    end

    assign STALL_CNT = stall_cnt_q;
    assign FLUSH_CNT = flush_cnt_q;
    assign IMISS_CNT = imiss_cnt_q;

endmodule
`endif

`default_nettype wire

// File: rtl/if_fetch_stage.sv
// ============================================================================
// Module      : if_fetch_stage
// Description : MIPS IF stage: PC register, IMEM address and IF/ID register.
//               Optional counters enabled by defining IF_PERFCNT_EN.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module if_fetch_stage
    import yep_if_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = DEF_RESET_VECTOR,
    parameter logic [31:0] NOP_WORD     = DEF_NOP_WORD
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        WPCIR,
    input  logic        BRANCH,
    input  logic [31:0] REDIR_PC,
    input  logic        SMC,
    input  logic        SMC2,
    input  logic        IMEM_READY,
    input  logic [31:0] IMEM_RDATA,
    output logic [31:0] IMEM_ADDR,
    output logic [31:0] IFPC,
    output logic [31:0] IDPC,
    output logic [31:0] IDIR,
    output logic        IDVALID
`ifdef IF_PERFCNT_EN
    ,
    output logic [31:0] STALL_CNT,
    output logic [31:0] FLUSH_CNT,
    output logic [31:0] IMISS_CNT
`endif
);

    logic [31:0] pc_q,      pc_d;
    logic [31:0] idpc_q,    idpc_d;
    logic [31:0] idir_q,    idir_d;
    logic        idvalid_q, idvalid_d;
    if_action_e  act;

    // SMC outranks WPCIR because the controller raises both together.
    always_comb begin
        if (SMC)              act = ACT_SMC;
        else if (WPCIR)       act = ACT_STALL;
        else if (BRANCH)      act = ACT_REDIR;
        else if (SMC2)        act = ACT_SMC2;
        else if (!IMEM_READY) act = ACT_MISS;
        else                  act = ACT_FETCH;
    end

    always_comb begin
        pc_d      = pc_q;
        idpc_d    = pc_q;
        idir_d    = NOP_WORD;
        idvalid_d = 1'b0;
        case (act)
            ACT_SMC:   pc_d = idpc_q;
            ACT_STALL: begin
                idpc_d    = idpc_q;
                idir_d    = idir_q;
                idvalid_d = idvalid_q;
            end
            ACT_REDIR: pc_d = REDIR_PC;
            ACT_FETCH: begin
                pc_d      = pc_q + PC_INC;
                idir_d    = IMEM_RDATA;
                idvalid_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pc_q      <= RESET_VECTOR;
            idpc_q    <= RESET_VECTOR;
            idir_q    <= NOP_WORD;
            idvalid_q <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            idpc_q    <= idpc_d;
            idir_q    <= idir_d;
            idvalid_q <= idvalid_d;
        end
    end

    assign IMEM_ADDR = pc_q;
    assign IFPC      = pc_q;
    assign IDPC      = idpc_q;
    assign IDIR      = idir_q;
    assign IDVALID   = idvalid_q;

`ifdef IF_PERFCNT_EN
    if_perfcnt u_perfcnt (
        .CLK       (CLK),
        .RST       (RST),
        .act       (act),
        .STALL_CNT (STALL_CNT),
        .FLUSH_CNT (FLUSH_CNT),
        .IMISS_CNT (IMISS_CNT)
    );
`endif

endmodule

`default_nettype wire

// File: tb/tb_if_fetch_stage.sv
// ============================================================================
// Module      : tb_if_fetch_stage
// Description : Directed self-checking bench for if_fetch_stage.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_if_fetch_stage;
    import yep_if_pkg::*;

    logic        CLK = 1'b0;
    logic        RST, WPCIR, BRANCH, SMC, SMC2, IMEM_READY;
    logic [31:0] REDIR_PC, IMEM_RDATA, IMEM_ADDR, IFPC, IDPC, IDIR;
    logic        IDVALID;
    logic        smc_new;
`ifdef IF_PERFCNT_EN
    logic [31:0] STALL_CNT, FLUSH_CNT, IMISS_CNT;
`endif

    int checks = 0;
    int errors = 0;
    int exp_stall = 0, exp_flush = 0, exp_miss = 0;

    if_fetch_stage dut (
        .CLK        (CLK),
        .RST        (RST),
        .WPCIR      (WPCIR),
        .BRANCH     (BRANCH),
        .REDIR_PC   (REDIR_PC),
        .SMC        (SMC),
        .SMC2       (SMC2),
        .IMEM_READY (IMEM_READY),
        .IMEM_RDATA (IMEM_RDATA),
        .IMEM_ADDR  (IMEM_ADDR),
        .IFPC       (IFPC),
        .IDPC       (IDPC),
        .IDIR       (IDIR),
        .IDVALID    (IDVALID)
`ifdef IF_PERFCNT_EN
        ,
        .STALL_CNT  (STALL_CNT),
        .FLUSH_CNT  (FLUSH_CNT),
        .IMISS_CNT  (IMISS_CNT)
`endif
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return a ^ 32'hDEAD_BEEF;
    endfunction

    // Word at 0x20 is overwritten by the store that triggers SMC.
    always_comb begin
        if (smc_new && IMEM_ADDR == 32'h20) IMEM_RDATA = 32'h1234_5678;
        else                                IMEM_RDATA = mem(IMEM_ADDR);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_id(input string tag, input logic [31:0] pc, input logic [31:0] idpc,
                          input logic [31:0] idir, input logic v);
        chk({tag, ".IFPC"},    IFPC, pc);
        chk({tag, ".ADDR"},    IMEM_ADDR, pc);
        chk({tag, ".IDPC"},    IDPC, idpc);
        chk({tag, ".IDIR"},    IDIR, idir);
        chk({tag, ".IDVALID"}, {31'd0, IDVALID}, {31'd0, v});
    endtask

    // Tallies the event the counters should see, then advances one edge.
    task automatic tick();
        if_action_e a;
        if (SMC)              a = ACT_SMC;
        else if (WPCIR)       a = ACT_STALL;
        else if (BRANCH)      a = ACT_REDIR;
        else if (SMC2)        a = ACT_SMC2;
        else if (!IMEM_READY) a = ACT_MISS;
        else                  a = ACT_FETCH;
        if (!RST) begin
            if (a == ACT_STALL) exp_stall++;
            else if (a == ACT_MISS) exp_miss++;
            else if (a != ACT_FETCH) exp_flush++;
        end
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RST = 1'b1; WPCIR = 1'b0; BRANCH = 1'b0; SMC = 1'b0; SMC2 = 1'b0;
        IMEM_READY = 1'b1; REDIR_PC = '0; smc_new = 1'b0;
        #1;
        chk_id("reset", 32'h0, 32'h0, DEF_NOP_WORD, 1'b0);
        tick();
        tick();
        RST = 1'b0;

        tick(); chk_id("fetch0", 32'h4, 32'h0, mem(32'h0), 1'b1);
        tick(); chk_id("fetch4", 32'h8, 32'h4, mem(32'h4), 1'b1);
        tick(); tick();
        chk("at10", IFPC, 32'h10);

        BRANCH = 1'b1; REDIR_PC = 32'h40;
        tick(); chk_id("redir", 32'h40, 32'h10, DEF_NOP_WORD, 1'b0);
        BRANCH = 1'b0;
        tick(); chk_id("redir_tgt", 32'h44, 32'h40, mem(32'h40), 1'b1);

        WPCIR = 1'b1; BRANCH = 1'b1; REDIR_PC = 32'h80;
        tick(); chk_id("stall1", 32'h44, 32'h40, mem(32'h40), 1'b1);
        tick(); chk_id("stall2", 32'h44, 32'h40, mem(32'h40), 1'b1);
        WPCIR = 1'b0;
        tick(); chk_id("post_stall_br", 32'h80, 32'h44, DEF_NOP_WORD, 1'b0);
        BRANCH = 1'b0;

        BRANCH = 1'b1; REDIR_PC = 32'h1C;
        tick();
        BRANCH = 1'b0;
        tick(); tick();
        chk_id("pre_smc", 32'h24, 32'h20, mem(32'h20), 1'b1);
        SMC = 1'b1; WPCIR = 1'b1; smc_new = 1'b1;
        tick(); chk_id("smc", 32'h20, 32'h24, DEF_NOP_WORD, 1'b0);
        SMC = 1'b0; WPCIR = 1'b0;
        tick(); chk_id("smc_refetch", 32'h24, 32'h20, 32'h1234_5678, 1'b1);

        SMC2 = 1'b1;
        tick(); chk_id("smc2", 32'h24, 32'h24, DEF_NOP_WORD, 1'b0);
        SMC2 = 1'b0;
        tick(); chk_id("smc2_refetch", 32'h28, 32'h24, mem(32'h24), 1'b1);

        IMEM_READY = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(); chk_id("miss", 32'h28, 32'h28, DEF_NOP_WORD, 1'b0);
        end
        IMEM_READY = 1'b1;
        tick(); chk_id("miss_done", 32'h2C, 32'h28, mem(32'h28), 1'b1);
`ifdef IF_PERFCNT_EN
        chk("IMISS_CNT", IMISS_CNT, 32'd3);
        chk("IMISS_model", IMISS_CNT, exp_miss);
        chk("STALL_CNT", STALL_CNT, 32'd2);
        chk("FLUSH_CNT", FLUSH_CNT, 32'd5);
        chk("FLUSH_model", FLUSH_CNT, exp_flush);
        chk("STALL_model", STALL_CNT, exp_stall);
`endif

        BRANCH = 1'b1; REDIR_PC = 32'hFFFF_FFFC;
        tick(); chk("wrap_pc", IFPC, 32'hFFFF_FFFC);
        BRANCH = 1'b0;
        tick(); chk_id("wrap", 32'h0, 32'hFFFF_FFFC, mem(32'hFFFF_FFFC), 1'b1);
        tick();
        WPCIR = 1'b1;
        tick(); chk_id("pre_rst_stall", 32'h4, 32'h0, mem(32'h0), 1'b1);
        #2 RST = 1'b1;
        #1;
        chk_id("async_rst", 32'h0, 32'h0, DEF_NOP_WORD, 1'b0);
`ifdef IF_PERFCNT_EN
        chk("rst_STALL_CNT", STALL_CNT, 32'd0);
        chk("rst_FLUSH_CNT", FLUSH_CNT, 32'd0);
        chk("rst_IMISS_CNT", IMISS_CNT, 32'd0);
`endif
        tick();
        WPCIR = 1'b0; RST = 1'b0;
        tick(); chk_id("after_rst", 32'h4, 32'h0, mem(32'h0), 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/if_fetch_stage.md
# if_fetch_stage

Instruction-fetch stage of the pipelined MIPS core. It owns the PC register, drives the instruction-memory address, and holds the IF/ID pipeline register feeding the ID-stage controller. It consumes the controller's stall (WPCIR), redirect (BRANCH plus target) and self-modifying-code (SMC, SMC2) indications, and produces IFPC, IDPC and IDIR.

## Interface
Parameters:
- RESET_VECTOR, 32'h0000_0000: PC value loaded on reset.
- NOP_WORD, 32'h0000_0000: bubble instruction (sll $0,$0,0), which decodes with no side effect.

Ports (reset asynchronous, active-high):
- CLK  in  1  core clock; all state updates on the rising edge.
- RST  in  1  asynchronous, active-high reset.
- WPCIR  in  1  stall from ID; hold PC and IF/ID.
- BRANCH  in  1  redirect request from ID (taken branch, mispredict correction, J, JAL, JR).
- REDIR_PC  in  32  redirect target, already selected by the ID datapath.
- SMC  in  1  store in EX hits IDPC; the ID instruction is stale.
- SMC2  in  1  store in EX hits IFPC; the IF instruction is stale.
- IMEM_READY  in  1  instruction memory has valid data this cycle.
- IMEM_RDATA  in  32  instruction word at IMEM_ADDR (combinational read).
- IMEM_ADDR  out  32  fetch address; always equal to the PC register.
- IFPC  out  32  PC of the instruction in IF (the PC register).
- IDPC  out  32  PC of the instruction in the IF/ID register.
- IDIR  out  32  instruction in the IF/ID register.
- IDVALID  out  1  1 = IDIR is a real instruction; 0 = bubble.

## Operation
- Reset values: PC=RESET_VECTOR, IDIR=NOP_WORD, IDPC=RESET_VECTOR, IDVALID=0, counters=0.
- Each edge applies exactly one action. Priority is highest first:
  1. **SMC:** PC<=IDPC; IF/ID<=bubble. The stale ID instruction is refetched after the store commits. WPCIR is ignored, because the controller raises it alongside SMC.
  2. **WPCIR:** PC, IDPC, IDIR and IDVALID all hold. A BRANCH in the same cycle is ignored; ID re-asserts it after the stall clears.
  3. **BRANCH:** PC<=REDIR_PC; IF/ID<=bubble. This squashes the wrong-path instruction. There is no delay slot.
  4. **SMC2:** PC holds (refetches IFPC); IF/ID<=bubble.
  5. **!IMEM_READY:** PC holds; IF/ID<=bubble.
  6. **Normal:** IDIR<=IMEM_RDATA; IDPC<=PC; IDVALID<=1; PC<=PC+4.
- A bubble writes IDIR<=NOP_WORD, IDPC<=PC (current) and IDVALID<=0.
- PC arithmetic is 32-bit unsigned. It wraps from 32'hFFFF_FFFC to 0 with no flag. Bits [1:0] are carried through unchanged; alignment is checked elsewhere.
- Reset asserted mid-stall or mid-redirect returns all state to the reset values immediately. No pending redirect survives reset.

## Timing
- Fetch to ID: 1 cycle. The word at PC is visible on IDIR the cycle after the edge that samples it.
- Redirect penalty: 1 bubble. REDIR_PC is sampled at edge N, appears on IFPC after N, and its instruction reaches IDIR after N+1.
- Stall: WPCIR is asserted at edge N, so IDIR/IDPC are unchanged after N. Stall length is unbounded.
- SMC refetch: 1 bubble plus the refetch. SMC2: 1 bubble.
- Outputs are registered, except IMEM_ADDR/IFPC, which equal the PC register directly.

## Configuration
- IF_PERFCNT_EN defined:
  - Adds three 32-bit wrapping counters: STALL_CNT (WPCIR cycles), FLUSH_CNT (BRANCH/SMC/SMC2 bubbles) and IMISS_CNT (!IMEM_READY bubbles).
  - Each counter counts only the action actually taken under the priority above.
  - Exposed as outputs of the same names; reset to 0.
- IF_PERFCNT_EN undefined: counters and ports are absent. Fetch behaviour is identical.

## Structure
- Shared package yep_if_pkg holds:
  - the NOP_WORD and RESET_VECTOR defaults;
  - the PC increment constant (4);
  - an action enum {ACT_SMC, ACT_STALL, ACT_REDIR, ACT_SMC2, ACT_MISS, ACT_FETCH}, used by both the RTL and the bench scoreboard.
- The priority encoder producing the action is combinational logic in the top module.
- Sub-module if_perfcnt holds the counters, compiled only under IF_PERFCNT_EN.

## Test plan
- **Reset, then IMEM_READY=1:**
  - After RST drops, IFPC steps 0, 4, 8.
  - IDIR carries the memory words at 0, 4 with IDPC 0, 4, and IDVALID rises 1 cycle after the first fetch.
- **Redirect:** BRANCH=1, REDIR_PC=32'h40 while IFPC=32'h10 -> next cycle IFPC=32'h40 and IDIR=NOP_WORD with IDVALID=0; the following cycle IDIR=mem[0x40], IDPC=32'h40.
- **Stall over branch:** WPCIR=1 and BRANCH=1 for 2 cycles -> IFPC, IDPC and IDIR are frozen and the redirect is not taken; after WPCIR drops, BRANCH alone redirects.
- **SMC:**
  - Case A: IDPC=32'h20, SMC=1 and WPCIR=1 -> next IFPC=32'h20 and the ID stage holds a bubble; the new mem[0x20] then appears on IDIR.
  - Case B: SMC2=1 at IFPC=32'h24 -> IFPC holds at 32'h24 and one bubble is inserted.
- **Memory wait:**
  - IMEM_READY=0 for 3 cycles -> IFPC holds and 3 bubbles are issued.
  - With IF_PERFCNT_EN, IMISS_CNT=3.
- **Wrap and async reset:**
  - PC at 32'hFFFF_FFFC fetches, then the next PC is 0.
  - RST asserted mid-stall -> all outputs take their reset values before the next edge.
